// File: rtl/alu_iter_if.sv
// alu_iter_if: request/result handshake bundle for alu_iter.
// master: in_valid, bus_a, bus_b, alu_ctrl, out_ready out; in_ready, out_valid, bus_w, flags in.
interface alu_iter_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] bus_a;
   logic [WIDTH-1:0] bus_b;
   logic [3:0]       alu_ctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] bus_w;
   logic             zero;
   logic             overflow;
   logic             carry_out;

   modport master (
      output in_valid, bus_a, bus_b, alu_ctrl, out_ready,
      input  in_ready, out_valid, bus_w, zero, overflow, carry_out
   );

   modport slave (
      input  in_valid, bus_a, bus_b, alu_ctrl, out_ready,
      output in_ready, out_valid, bus_w, zero, overflow, carry_out
   );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU, single-cycle ops plus iterative shift-add MUL.
// Ports: clk, rst (async, active high), bus (alu_iter_if.slave).
module alu_iter #(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input logic       clk,
   input logic       rst,
   alu_iter_if.slave bus
);
   localparam int SW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND    = 4'b0000;
   localparam logic [3:0] OP_OR     = 4'b0001;
   localparam logic [3:0] OP_ADD    = 4'b0010;
   localparam logic [3:0] OP_SLT    = 4'b0011;
   localparam logic [3:0] OP_MUL    = 4'b0100;
   localparam logic [3:0] OP_SUB    = 4'b0110;
   localparam logic [3:0] OP_PASSB  = 4'b0111;
   localparam logic [3:0] OP_PASSBM = 4'b1000;
   localparam logic [3:0] OP_SLL    = 4'b1001;
   localparam logic [3:0] OP_SRL    = 4'b1010;

   typedef enum logic [1:0] {IDLE, MUL_RUN, OUT_HOLD} state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] a_q, b_q, acc_q, w_q;
   logic [SW-1:0]    cnt_q;
   logic             vld_q, z_q, ov_q, c_q;

   logic             in_ready, accept, consume, is_mul, mul_last;
   logic [WIDTH-1:0] res, mul_sum;
   logic             res_ov, res_c;
   logic [WIDTH:0]   ext;

   assign in_ready = (state != MUL_RUN) && (!vld_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign consume  = vld_q && bus.out_ready;
   assign is_mul   = (MUL_EN != 0) && (bus.alu_ctrl == OP_MUL);

   // One shift-add step: A shifts left, B shifts right, LSB of B gates A.
   assign mul_sum  = acc_q + (b_q[0] ? a_q : '0);
   assign mul_last = (cnt_q == SW'(WIDTH - 1));

   always_comb begin
      res    = '0;
      res_ov = 1'b0;
      res_c  = 1'b0;
      ext    = '0;
      case (bus.alu_ctrl)
         OP_AND: res = bus.bus_a & bus.bus_b;
         OP_OR:  res = bus.bus_a | bus.bus_b;
         OP_ADD: begin
            ext    = {1'b0, bus.bus_a} + {1'b0, bus.bus_b};
            res    = ext[WIDTH-1:0];
            res_c  = ext[WIDTH];
            res_ov = (bus.bus_a[WIDTH-1] == bus.bus_b[WIDTH-1]) &&
                     (res[WIDTH-1] != bus.bus_a[WIDTH-1]);
         end
         OP_SUB: begin
            // Top bit of the extended difference is the borrow (A < B).
            ext    = {1'b0, bus.bus_a} - {1'b0, bus.bus_b};
            res    = ext[WIDTH-1:0];
            res_c  = ext[WIDTH];
            res_ov = (bus.bus_a[WIDTH-1] != bus.bus_b[WIDTH-1]) &&
                     (res[WIDTH-1] != bus.bus_a[WIDTH-1]);
         end
         OP_PASSB, OP_PASSBM: res = bus.bus_b;
         OP_SLT: res = {{(WIDTH-1){1'b0}},
                        ($signed(bus.bus_a) < $signed(bus.bus_b))};
         OP_SLL: res = bus.bus_a << bus.bus_b[SW-1:0];
         OP_SRL: res = bus.bus_a >> bus.bus_b[SW-1:0];
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         MUL_RUN: begin
            if (mul_last) state_n = OUT_HOLD;
         end
         default: begin
            if (accept)       state_n = is_mul ? MUL_RUN : OUT_HOLD;
            else if (consume) state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         w_q   <= '0;
         z_q   <= 1'b1;
         ov_q  <= 1'b0;
         c_q   <= 1'b0;
         vld_q <= 1'b0;
      end else if (state == MUL_RUN) begin
         // Final step writes its sum straight into the result register.
         if (mul_last) begin
            w_q   <= mul_sum;
            z_q   <= (mul_sum == '0);
            ov_q  <= 1'b0;
            c_q   <= 1'b0;
            vld_q <= 1'b1;
         end else begin
            acc_q <= mul_sum;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + SW'(1);
         end
      end else if (accept) begin
         if (is_mul) begin
            a_q   <= bus.bus_a;
            b_q   <= bus.bus_b;
            acc_q <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
         end else begin
            w_q   <= res;
            z_q   <= (res == '0);
            ov_q  <= res_ov;
            c_q   <= res_c;
            vld_q <= 1'b1;
         end
      end else if (consume) begin
         vld_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = vld_q;
   assign bus.bus_w     = w_q;
   assign bus.zero      = z_q;
   assign bus.overflow  = ov_q;
   assign bus.carry_out = c_q;
endmodule
